// File: rtl/parking_gate_arbiter_if.sv
// rtl/parking_gate_arbiter_if.sv - lane request, auth, gate and occupancy signals of the parking gate arbiter
interface parking_gate_arbiter_if #(
  parameter int CNT_W = 4
);
  logic             entry_req;
  logic             exit_req;
  logic             auth_valid;
  logic             auth_ok;
  logic             pass_sensor;
  logic             gate_open;
  logic             entry_grant;
  logic             exit_grant;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             reject;
  logic             timeout_err;

  // Sensor / auth front-end side: drives requests, observes gate state.
  modport master (
    output entry_req, exit_req, auth_valid, auth_ok, pass_sensor,
    input  gate_open, entry_grant, exit_grant, occupancy, full, empty, reject, timeout_err
  );

  // Arbiter side.
  modport slave (
    input  entry_req, exit_req, auth_valid, auth_ok, pass_sensor,
    output gate_open, entry_grant, exit_grant, occupancy, full, empty, reject, timeout_err
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - round-robin entry/exit arbiter for a shared barrier gate with occupancy count
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int AUTH_TIMEOUT = 16,
  parameter int PASS_TIMEOUT = 32,
  parameter int CLOSE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_gate_arbiter_if.slave bus
);

  localparam int TMR_MAX_A = (AUTH_TIMEOUT > PASS_TIMEOUT) ? AUTH_TIMEOUT : PASS_TIMEOUT;
  localparam int TMR_MAX   = (TMR_MAX_A > CLOSE_CYCLES) ? TMR_MAX_A : CLOSE_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_AUTH, S_OPEN, S_CLOSE} state_e;
  typedef enum logic {LANE_EXIT, LANE_ENTRY} lane_e;

  state_e           state_q;
  lane_e            lane_q;
  lane_e            last_served_q;
  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic             full_q;
  logic             empty_q;
  logic             gate_open_q;
  logic             entry_grant_q;
  logic             exit_grant_q;
  logic             reject_q;
  logic             timeout_err_q;

  logic entry_ok;
  logic exit_ok;
  logic serve_entry;

  // Lane eligibility, round-robin pick and saturating next occupancy.
  always_comb begin
    entry_ok    = bus.entry_req & ~full_q;
    exit_ok     = bus.exit_req & ~empty_q;
    serve_entry = entry_ok;
    if (entry_ok && exit_ok) begin
      serve_entry = (last_served_q == LANE_EXIT);
    end
    occ_d = occ_q;
    if (state_q == S_OPEN && bus.pass_sensor) begin
      if (lane_q == LANE_ENTRY) begin
        if (occ_q < CNT_W'(CAPACITY)) occ_d = occ_q + CNT_W'(1);
      end else begin
        if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
      end
    end
  end

  // Gate sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lane_q        <= LANE_EXIT;
      last_served_q <= LANE_EXIT;
      timer_q       <= '0;
      occ_q         <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      gate_open_q   <= 1'b0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      reject_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      reject_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      occ_q         <= occ_d;
      full_q        <= (occ_d == CNT_W'(CAPACITY));
      empty_q       <= (occ_d == '0);
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (entry_ok || exit_ok) begin
            if (serve_entry) begin
              lane_q        <= LANE_ENTRY;
              last_served_q <= LANE_ENTRY;
              entry_grant_q <= 1'b1;
              state_q       <= S_AUTH;
            end else begin
              lane_q        <= LANE_EXIT;
              last_served_q <= LANE_EXIT;
              exit_grant_q  <= 1'b1;
              gate_open_q   <= 1'b1;
              state_q       <= S_OPEN;
            end
          end
        end
        S_AUTH: begin
          if (bus.auth_valid && bus.auth_ok) begin
            gate_open_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= S_OPEN;
          end else if (bus.auth_valid || timer_q == TMR_W'(AUTH_TIMEOUT - 1)) begin
            reject_q      <= 1'b1;
            entry_grant_q <= 1'b0;
            timer_q       <= '0;
            state_q       <= S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_OPEN: begin
          if (bus.pass_sensor || timer_q == TMR_W'(PASS_TIMEOUT - 1)) begin
            // A pass on the final cycle wins over the timeout.
            timeout_err_q <= ~bus.pass_sensor;
            gate_open_q   <= 1'b0;
            timer_q       <= '0;
            state_q       <= S_CLOSE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_CLOSE: begin
          if (timer_q == TMR_W'(CLOSE_CYCLES - 1)) begin
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            timer_q       <= '0;
            state_q       <= S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gate_open   = gate_open_q;
  assign bus.entry_grant = entry_grant_q;
  assign bus.exit_grant  = exit_grant_q;
  assign bus.occupancy   = occ_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.reject      = reject_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed self-checking bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   failed = 0;
  int   overlap = 0;

  parking_gate_arbiter_if #(.CNT_W(4)) bus ();

  parking_gate_arbiter #(
    .CAPACITY(8), .CNT_W(4), .AUTH_TIMEOUT(16), .PASS_TIMEOUT(32), .CLOSE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Grants must never be high together.
  always @(negedge clk) if (bus.entry_grant && bus.exit_grant) overlap++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic entry_cycle();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    bus.auth_valid = 1'b1;
    bus.auth_ok = 1'b1;
    tick();
    bus.auth_valid = 1'b0;
    bus.pass_sensor = 1'b1;
    tick();
    bus.pass_sensor = 1'b0;
    repeat (4) tick();
  endtask

  task automatic exit_cycle();
    bus.exit_req = 1'b1;
    tick();
    bus.exit_req = 1'b0;
    bus.pass_sensor = 1'b1;
    tick();
    bus.pass_sensor = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    bus.entry_req = 0; bus.exit_req = 0; bus.auth_valid = 0; bus.auth_ok = 0; bus.pass_sensor = 0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tests_run++;
    if ({bus.gate_open, bus.entry_grant, bus.exit_grant, bus.full, bus.empty, bus.reject, bus.timeout_err} !== 7'b0000100) begin
      failed++; $display("FAIL reset_flags got %b exp 0000100", {bus.gate_open, bus.entry_grant, bus.exit_grant, bus.full, bus.empty, bus.reject, bus.timeout_err});
    end
    tests_run++;
    if (bus.occupancy !== 4'd0) begin failed++; $display("FAIL reset_occ got %0d exp 0", bus.occupancy); end
    bus.exit_req = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({bus.exit_grant, bus.gate_open, bus.empty} !== 3'b001) begin
      failed++; $display("FAIL exit_when_empty got %b exp 001", {bus.exit_grant, bus.gate_open, bus.empty});
    end
    bus.exit_req = 1'b0;
  endtask

  task automatic test_entry_pass();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    tests_run++;
    if ({bus.entry_grant, bus.gate_open} !== 2'b10) begin failed++; $display("FAIL entry_auth got %b exp 10", {bus.entry_grant, bus.gate_open}); end
    tick();
    bus.auth_valid = 1'b1; bus.auth_ok = 1'b1;
    tick();
    bus.auth_valid = 1'b0;
    tests_run++;
    if ({bus.gate_open, bus.occupancy} !== {1'b1, 4'd0}) begin failed++; $display("FAIL entry_open got %b/%0d exp 1/0", bus.gate_open, bus.occupancy); end
    bus.pass_sensor = 1'b1;
    tick();
    bus.pass_sensor = 1'b0;
    tests_run++;
    if ({bus.gate_open, bus.entry_grant, bus.empty, bus.occupancy} !== {3'b010, 4'd1}) begin
      failed++; $display("FAIL entry_passed got %b/%0d exp 010/1", {bus.gate_open, bus.entry_grant, bus.empty}, bus.occupancy);
    end
    repeat (3) tick();
    tests_run++;
    if (bus.entry_grant !== 1'b1) begin failed++; $display("FAIL close_held got %b exp 1", bus.entry_grant); end
    tick();
    tests_run++;
    if (bus.entry_grant !== 1'b0) begin failed++; $display("FAIL close_end got %b exp 0", bus.entry_grant); end
  endtask

  task automatic test_reject();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    bus.auth_valid = 1'b1; bus.auth_ok = 1'b0;
    tick();
    bus.auth_valid = 1'b0;
    tests_run++;
    if ({bus.reject, bus.entry_grant, bus.gate_open, bus.occupancy} !== {3'b100, 4'd1}) begin
      failed++; $display("FAIL auth_fail got %b/%0d exp 100/1", {bus.reject, bus.entry_grant, bus.gate_open}, bus.occupancy);
    end
    tick();
    tests_run++;
    if (bus.reject !== 1'b0) begin failed++; $display("FAIL reject_pulse got %b exp 0", bus.reject); end
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    repeat (15) tick();
    tests_run++;
    if ({bus.reject, bus.entry_grant} !== 2'b01) begin failed++; $display("FAIL auth_wait15 got %b exp 01", {bus.reject, bus.entry_grant}); end
    tick();
    tests_run++;
    if ({bus.reject, bus.entry_grant, bus.gate_open} !== 3'b100) begin
      failed++; $display("FAIL auth_timeout got %b exp 100", {bus.reject, bus.entry_grant, bus.gate_open});
    end
    tick();
  endtask

  task automatic test_full();
    repeat (7) entry_cycle();
    tests_run++;
    if ({bus.full, bus.occupancy} !== {1'b1, 4'd8}) begin failed++; $display("FAIL fill got %b/%0d exp 1/8", bus.full, bus.occupancy); end
    bus.entry_req = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({bus.entry_grant, bus.gate_open} !== 2'b00) begin failed++; $display("FAIL entry_when_full got %b exp 00", {bus.entry_grant, bus.gate_open}); end
    bus.entry_req = 1'b0;
    exit_cycle();
    tests_run++;
    if ({bus.full, bus.occupancy} !== {1'b0, 4'd7}) begin failed++; $display("FAIL exit_from_full got %b/%0d exp 0/7", bus.full, bus.occupancy); end
  endtask

  task automatic test_round_robin();
    repeat (4) exit_cycle();
    bus.entry_req = 1'b1; bus.exit_req = 1'b1;
    tick();
    tests_run++;
    if ({bus.entry_grant, bus.exit_grant} !== 2'b10) begin failed++; $display("FAIL rr_first got %b exp 10", {bus.entry_grant, bus.exit_grant}); end
    bus.auth_valid = 1'b1; bus.auth_ok = 1'b1;
    tick();
    bus.auth_valid = 1'b0; bus.pass_sensor = 1'b1;
    tick();
    bus.pass_sensor = 1'b0;
    tests_run++;
    if (bus.occupancy !== 4'd4) begin failed++; $display("FAIL rr_entry_occ got %0d exp 4", bus.occupancy); end
    repeat (5) tick();
    tests_run++;
    if ({bus.entry_grant, bus.exit_grant, bus.gate_open} !== 3'b011) begin
      failed++; $display("FAIL rr_second got %b exp 011", {bus.entry_grant, bus.exit_grant, bus.gate_open});
    end
    bus.pass_sensor = 1'b1;
    tick();
    bus.pass_sensor = 1'b0;
    tests_run++;
    if (bus.occupancy !== 4'd3) begin failed++; $display("FAIL rr_exit_occ got %0d exp 3", bus.occupancy); end
    repeat (5) tick();
    tests_run++;
    if ({bus.entry_grant, bus.exit_grant} !== 2'b10) begin failed++; $display("FAIL rr_third got %b exp 10", {bus.entry_grant, bus.exit_grant}); end
    bus.entry_req = 1'b0; bus.exit_req = 1'b0;
    bus.auth_valid = 1'b1; bus.auth_ok = 1'b0;
    tick();
    bus.auth_valid = 1'b0;
    tick();
    tests_run++;
    if (overlap !== 0) begin failed++; $display("FAIL grant_overlap got %0d exp 0", overlap); end
  endtask

  task automatic test_pass_timeout();
    bus.exit_req = 1'b1;
    tick();
    bus.exit_req = 1'b0;
    repeat (31) tick();
    tests_run++;
    if ({bus.timeout_err, bus.gate_open} !== 2'b01) begin failed++; $display("FAIL open_wait31 got %b exp 01", {bus.timeout_err, bus.gate_open}); end
    tick();
    tests_run++;
    if ({bus.timeout_err, bus.gate_open, bus.exit_grant, bus.occupancy} !== {3'b101, 4'd3}) begin
      failed++; $display("FAIL pass_timeout got %b/%0d exp 101/3", {bus.timeout_err, bus.gate_open, bus.exit_grant}, bus.occupancy);
    end
    tick();
    tests_run++;
    if (bus.timeout_err !== 1'b0) begin failed++; $display("FAIL timeout_pulse got %b exp 0", bus.timeout_err); end
    repeat (3) tick();
    bus.exit_req = 1'b1;
    tick();
    bus.exit_req = 1'b0;
    repeat (31) tick();
    bus.pass_sensor = 1'b1;
    tick();
    bus.pass_sensor = 1'b0;
    tests_run++;
    if ({bus.timeout_err, bus.occupancy} !== {1'b0, 4'd2}) begin
      failed++; $display("FAIL pass_on_last got %b/%0d exp 0/2", bus.timeout_err, bus.occupancy);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_open();
    bus.exit_req = 1'b1;
    tick();
    bus.exit_req = 1'b0;
    tests_run++;
    if (bus.gate_open !== 1'b1) begin failed++; $display("FAIL pre_reset_open got %b exp 1", bus.gate_open); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({bus.gate_open, bus.exit_grant, bus.empty, bus.occupancy} !== {3'b001, 4'd0}) begin
      failed++; $display("FAIL reset_mid_open got %b/%0d exp 001/0", {bus.gate_open, bus.exit_grant, bus.empty}, bus.occupancy);
    end
    repeat (2) tick();
    tests_run++;
    if ({bus.gate_open, bus.entry_grant, bus.exit_grant} !== 3'b000) begin
      failed++; $display("FAIL post_reset_idle got %b exp 000", {bus.gate_open, bus.entry_grant, bus.exit_grant});
    end
  endtask

  initial begin
    test_reset();
    test_entry_pass();
    test_reject();
    test_full();
    test_round_robin();
    test_pass_timeout();
    test_reset_mid_open();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
Controller that shares one barrier gate between an entry lane and an exit lane of the car park. It arbitrates lane requests with round-robin priority and sequences authorisation, gate open, car pass and gate close. It keeps the occupancy count and blocks entry when the park is full. It sits above the password/LED front-end, which supplies the auth result.

Parameters:
CAPACITY, 8, maximum number of parked cars (1..2**CNT_W-1)
CNT_W, 4, width of occupancy counter
AUTH_TIMEOUT, 16, cycles allowed in AUTH for an auth result
PASS_TIMEOUT, 32, cycles allowed in OPEN for pass_sensor
CLOSE_CYCLES, 4, cycles gate stays closed in CLOSE before next service

Ports:
clk  in  1  system clock; single clock domain, all logic on rising edge
reset  in  1  synchronous, active-high reset
entry_req  in  1  level: car waiting at entrance sensor
exit_req  in  1  level: car waiting at exit sensor
auth_valid  in  1  one-cycle pulse: password check result available
auth_ok  in  1  password correct; sampled only when auth_valid=1
pass_sensor  in  1  car has cleared the gate; sampled in OPEN only
gate_open  out  1  barrier open command
entry_grant  out  1  high while serving entry lane (AUTH, OPEN, CLOSE)
exit_grant  out  1  high while serving exit lane (OPEN, CLOSE)
occupancy  out  CNT_W  cars currently parked
full  out  1  occupancy == CAPACITY
empty  out  1  occupancy == 0
reject  out  1  one-cycle pulse: auth failed or auth timeout
timeout_err  out  1  one-cycle pulse: pass_sensor not seen within PASS_TIMEOUT

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, occupancy=0, empty=1, full=0, gate_open=0, grants=0, reject=0, timeout_err=0, last_served=EXIT (entry wins first tie), timer=0.
- Reset asserted mid-operation forces the reset values on the next edge. Gate closes and the count is lost.
- Eligibility: entry_ok = entry_req & ~full; exit_ok = exit_req & ~empty.
- IDLE:
  - Only exit_ok: latch lane=EXIT, set exit_grant, go OPEN.
  - Only entry_ok: latch lane=ENTRY, set entry_grant, go AUTH.
  - Both eligible: serve the lane opposite last_served.
  - last_served updates at grant.
  - Neither eligible: stay in IDLE.
- AUTH (entry only), timer counts from 0:
  - auth_valid & auth_ok: go OPEN.
  - auth_valid & ~auth_ok: reject=1 for one cycle, grant drops, go IDLE.
  - timer reaches AUTH_TIMEOUT-1 with no auth_valid: reject pulse, go IDLE.
  - auth_valid outside AUTH is ignored.
- OPEN: gate_open=1, timer counts from 0.
  - pass_sensor=1: occupancy +1 (ENTRY) or -1 (EXIT), go CLOSE.
  - timer reaches PASS_TIMEOUT-1 with no pass_sensor: timeout_err pulse, occupancy unchanged, go CLOSE.
  - pass_sensor on the timeout cycle counts as a pass, with no error.
- CLOSE: gate_open=0, grant held. After exactly CLOSE_CYCLES cycles, clear the grant and go IDLE.
- Occupancy arithmetic:
  - Never exceeds CAPACITY and never wraps below 0; saturation guards are required in RTL.
  - full and empty update on the same edge as occupancy.
  - Requests are ignored while not in IDLE; no queuing is needed because requests are levels.
- Latency: IDLE to gate_open is 1 cycle for exit and 2 cycles minimum for entry (auth in the first AUTH cycle).
- entry_grant and exit_grant are never high together.

Test Plan:
- After reset, exit_req=1 with occupancy=0 -> stays IDLE, exit_grant=0, empty=1.
- entry_req=1, auth_valid pulse with auth_ok=1 two cycles later, then pass_sensor -> gate_open high, occupancy 0→1, then CLOSE for 4 cycles, then IDLE.
- entry_req=1 with auth_valid & ~auth_ok -> reject pulse for 1 cycle, gate_open never 1, occupancy unchanged. Same with no auth for 16 cycles -> reject on cycle 16.
- Fill to occupancy=8 -> full=1; further entry_req is ignored. exit_req then pass_sensor -> occupancy 7, full=0.
- entry_req and exit_req held together with occupancy=3 -> grants alternate ENTRY, EXIT, ENTRY. Grants are never concurrent.
- In OPEN, no pass_sensor for 32 cycles -> timeout_err pulse, occupancy unchanged. Separately, reset asserted during OPEN -> next cycle gate_open=0, occupancy=0, state IDLE.
